emmu_table_init: RTL and testbench
==================================

// Module: emmu_table_init
// PURPOSE
//  Config-side front end for the emmu translation table. Forwards host register
//  write packets to the emmu write port and sweeps every table entry after reset
//  or on request, writing zero or identity mappings. Sits directly upstream of
//  the emmu reg_access/reg_packet port; init_done may gate mmu_en.
// PARAMETERS
//  AW         32            address width; PW = 2*AW+40
//  MAW        12            table index width; entries = 1<<MAW
//  BASE_ADDR  32'h000F0000  table base; bits [MAW+2:0] must be zero
//  INIT_MODE  0             0: all words zero; 1: identity (lo word = index)
//  AUTO_INIT  1             1: start a sweep on the first clock after reset release
// PORTS
//  clk             in   1   single clock
//  nreset          in   1   asynchronous active-low reset
//  clear_req       in   1   pulse; requests a full table sweep
//  host_access_in  in   1   valid host config packet
//  host_packet_in  in   PW  host packet, standard emesh layout
//  host_wait_out   out  1   pushback to host; high while sweeping
//  reg_access      out  1   valid packet to emmu
//  reg_packet      out  PW  packet to emmu
//  busy            out  1   sweep in progress
//  init_done       out  1   high after a sweep completes; cleared when a sweep starts
//  done_pulse      out  1   one-cycle pulse when a sweep completes
// BEHAVIOUR
//  - Packet layout for AW=32: [0] write, [2:1] datamode, [7:3] ctrlmode,
//    [39:8] dstaddr, [71:40] data, [103:72] srcaddr.
//  - Reset (async assert, sync release): state IDLE, counter 0, all outputs 0,
//    reg_packet 0.
//  - FSM states: IDLE, SWEEP, DONE.
//  - IDLE -> SWEEP when clear_req=1, or on the first cycle after reset if
//    AUTO_INIT=1. SWEEP -> DONE after the last word. DONE -> IDLE always.
//  - busy = (state != IDLE). host_wait_out = busy; it is a registered,
//    glitch-free signal.
//  - Host path, IDLE only: when host_access_in=1, reg_access<=1 and
//    reg_packet<=host_packet_in on the next cycle (1-cycle latency).
//    Packets are not modified or filtered.
//  - clear_req and host_access_in in the same IDLE cycle: the host packet is
//    forwarded, and the sweep's first write follows on the next cycle.
//  - Sweep counter cnt is MAW+1 bits, {idx, half}, and starts at 0.
//    One write is issued per SWEEP cycle, with reg_access=1 continuously.
//    Order: idx0 lo, idx0 hi, idx1 lo, ... idx(2^MAW-1) hi.
//    Total = 2^(MAW+1) cycles.
//  - Sweep packet: write=1, datamode=2'b10, ctrlmode=0, srcaddr=0,
//    dstaddr = BASE_ADDR | {cnt, 2'b00}, so bit2 = half and bits[MAW+2:3] = idx.
//  - Sweep data: half=1 -> 0. half=0 -> 0 (INIT_MODE=0) or zero-extended idx
//    (INIT_MODE=1).
//  - Counter wrap (cnt all ones): go to DONE. In the DONE cycle reg_access=0;
//    done_pulse and init_done are set on the register edge entering IDLE.
//  - clear_req while busy: ignored, not queued.
//  - init_done clears on entry to SWEEP and sets at completion.
//  - Reset mid-sweep: the sweep aborts immediately and init_done=0; with
//    AUTO_INIT=1 it restarts from cnt=0.
//  - No downstream pushback exists; every reg_access cycle is consumed.
// STRUCTURE
//  - Shared package (emesh pkg): packet field offsets, PW function,
//    datamode encodings (DM_WORD=2'b10).
//  - Local: state encoding (IDLE=2'd0, SWEEP=2'd1, DONE=2'd2).
//  - One sub-module: emesh2packet instance assembling the sweep packet from
//    fields. A mux selects it or host_packet_in ahead of the output register.
// TESTING (bench uses MAW=4, AW=32, BASE_ADDR=32'h000F0000)
//  1. Release reset, AUTO_INIT=1, INIT_MODE=1 -> 32 consecutive writes
//     starting the cycle after release. Write 0: dstaddr 000F0000, data 0.
//     Write 2: dstaddr 000F0008, data 1. Last: dstaddr 000F007C, data 0.
//     Then done_pulse=1 for one cycle and init_done=1.
//  2. IDLE, host write dstaddr 000F0010 data 12345678 -> reg_packet identical,
//     reg_access=1 exactly one cycle later; host_wait_out stays 0.
//  3. Host access held during sweep -> host_wait_out=1 for the full sweep.
//     The host packet emerges 1 cycle after the first IDLE cycle, never
//     interleaved with sweep writes.
//  4. clear_req pulsed at sweep write 10 -> no restart; exactly 32 writes and
//     one done_pulse.
//  5. nreset asserted at write 20 -> reg_access=0 and busy=0 asynchronously.
//     After release, the sweep restarts at 000F0000; init_done stays 0 until
//     the full 32 writes complete.
//  6. clear_req and host_access_in together in IDLE -> host packet forwarded
//     first, sweep write 0 on the following cycle; init_done drops when SWEEP
//     is entered.

Source files
------------

// File: rtl/emmu_table_init_pkg.sv
// rtl/emmu_table_init_pkg.sv - emesh packet layout and helpers shared by the table init slice
package emmu_table_init_pkg;

  localparam logic [1:0] DM_WORD = 2'b10;

  localparam int E_WRITE_LSB = 0;
  localparam int E_DMODE_LSB = 1;
  localparam int E_CTRL_LSB  = 3;
  localparam int E_DST_LSB   = 8;

  typedef struct packed {
    logic       write;
    logic [1:0] datamode;
    logic [4:0] ctrlmode;
  } emesh_ctrl_t;

  function automatic int emesh_pw(input int aw);
    return 2 * aw + 40;
  endfunction

  function automatic int emesh_data_lsb(input int aw);
    return E_DST_LSB + aw;
  endfunction

  function automatic int emesh_src_lsb(input int aw);
    return E_DST_LSB + 2 * aw;
  endfunction

endpackage

// File: rtl/emmu_table_init_emesh2packet.sv
// rtl/emmu_table_init_emesh2packet.sv - packs emesh fields into a flat packet
module emmu_table_init_emesh2packet
  import emmu_table_init_pkg::*;
#(
  parameter int AW = 32,
  localparam int PW = emesh_pw(AW)
) (
  input  emesh_ctrl_t   ctrl_i,
  input  logic [AW-1:0] dstaddr_i,
  input  logic [AW-1:0] data_i,
  input  logic [AW-1:0] srcaddr_i,
  output logic [PW-1:0] packet_o
);

  localparam int DATA_LSB = emesh_data_lsb(AW);
  localparam int SRC_LSB  = emesh_src_lsb(AW);
  // srcaddr takes whatever remains above the data field
  localparam int SW       = PW - SRC_LSB;

  always_comb begin
    packet_o                    = '0;
    packet_o[E_WRITE_LSB]       = ctrl_i.write;
    packet_o[E_DMODE_LSB +: 2]  = ctrl_i.datamode;
    packet_o[E_CTRL_LSB +: 5]   = ctrl_i.ctrlmode;
    packet_o[E_DST_LSB +: AW]   = dstaddr_i;
    packet_o[DATA_LSB +: AW]    = data_i;
    packet_o[SRC_LSB +: SW]     = SW'(srcaddr_i);
  end

endmodule

// File: rtl/emmu_table_init.sv
// rtl/emmu_table_init.sv - forwards host config writes to the emmu and sweeps the table on reset/request
module emmu_table_init
  import emmu_table_init_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            MAW       = 12,
  parameter logic [AW-1:0] BASE_ADDR = 'h000F0000,
  parameter int            INIT_MODE = 0,
  parameter int            AUTO_INIT = 1,
  localparam int           PW        = emesh_pw(AW)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear_req,
  input  logic          host_access_in,
  input  logic [PW-1:0] host_packet_in,
  output logic          host_wait_out,
  output logic          reg_access,
  output logic [PW-1:0] reg_packet,
  output logic          busy,
  output logic          init_done,
  output logic          done_pulse
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [MAW:0] CNT_ONE = {{MAW{1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [MAW:0]  cnt_q, cnt_d;
  logic          auto_q, auto_d;
  logic          busy_q, busy_d;
  logic          access_q, access_d;
  logic [PW-1:0] packet_q, packet_d;
  logic          init_done_q, init_done_d;
  logic          done_pulse_q, done_pulse_d;

  logic [MAW-1:0] sweep_idx;
  logic           sweep_half;
  logic [AW-1:0]  sweep_dst;
  logic [AW-1:0]  sweep_data;
  emesh_ctrl_t    sweep_ctrl;
  logic [PW-1:0]  sweep_packet;

  // cnt = {idx, half}, so shifting it left by two walks the table word by word
  assign sweep_idx  = cnt_q[MAW:1];
  assign sweep_half = cnt_q[0];
  assign sweep_dst  = BASE_ADDR | AW'({cnt_q, 2'b00});
  assign sweep_data = (INIT_MODE == 1 && !sweep_half) ? AW'(sweep_idx) : '0;

  always_comb begin
    sweep_ctrl          = '0;
    sweep_ctrl.write    = 1'b1;
    sweep_ctrl.datamode = DM_WORD;
  end

  emmu_table_init_emesh2packet #(
    .AW (AW)
  ) u_sweep_pkt (
    .ctrl_i    (sweep_ctrl),
    .dstaddr_i (sweep_dst),
    .data_i    (sweep_data),
    .srcaddr_i ('0),
    .packet_o  (sweep_packet)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    auto_d       = auto_q;
    access_d     = 1'b0;
    packet_d     = packet_q;
    init_done_d  = init_done_q;
    done_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (host_access_in) begin
          access_d = 1'b1;
          packet_d = host_packet_in;
        end
        // a simultaneous host packet still goes out first; the sweep follows
        if (clear_req || auto_q) begin
          state_d     = ST_SWEEP;
          cnt_d       = '0;
          auto_d      = 1'b0;
          init_done_d = 1'b0;
        end
      end
      ST_SWEEP: begin
        access_d = 1'b1;
        packet_d = sweep_packet;
        cnt_d    = cnt_q + CNT_ONE;
        if (&cnt_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        init_done_d  = 1'b1;
        done_pulse_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      auto_q       <= (AUTO_INIT != 0);
      busy_q       <= 1'b0;
      access_q     <= 1'b0;
      packet_q     <= '0;
      init_done_q  <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      auto_q       <= auto_d;
      busy_q       <= busy_d;
      access_q     <= access_d;
      packet_q     <= packet_d;
      init_done_q  <= init_done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign busy          = busy_q;
  assign host_wait_out = busy_q;
  assign reg_access    = access_q;
  assign reg_packet    = packet_q;
  assign init_done     = init_done_q;
  assign done_pulse    = done_pulse_q;

endmodule

// File: tb/tb_emmu_table_init.sv
// tb/tb_emmu_table_init.sv - directed self-checking bench for emmu_table_init
module tb_emmu_table_init;

  localparam int          AW   = 32;
  localparam int          MAW  = 4;
  localparam int          PW   = 2 * AW + 40;
  localparam logic [31:0] BASE = 32'h000F0000;

  logic          clk = 1'b0;
  logic          nreset;
  logic          clear_req;
  logic          host_access_in;
  logic [PW-1:0] host_packet_in;
  logic          host_wait_out;
  logic          reg_access;
  logic [PW-1:0] reg_packet;
  logic          busy;
  logic          init_done;
  logic          done_pulse;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  emmu_table_init #(
    .AW        (AW),
    .MAW       (MAW),
    .BASE_ADDR (BASE),
    .INIT_MODE (1),
    .AUTO_INIT (1)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .clear_req      (clear_req),
    .host_access_in (host_access_in),
    .host_packet_in (host_packet_in),
    .host_wait_out  (host_wait_out),
    .reg_access     (reg_access),
    .reg_packet     (reg_packet),
    .busy           (busy),
    .init_done      (init_done),
    .done_pulse     (done_pulse)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // write=1, datamode=word, ctrlmode=0 -> low byte 8'h05
  function automatic logic [PW-1:0] mk_pkt(input logic [31:0] dst, input logic [31:0] data,
                                           input logic [31:0] src);
    return {src, data, dst, 8'h05};
  endfunction

  function automatic logic [PW-1:0] sweep_exp(input int k);
    logic [31:0] dst;
    logic [31:0] data;
    dst  = BASE | (32'(k) << 2);
    data = (k % 2 == 0) ? 32'(k / 2) : 32'h0;
    return mk_pkt(dst, data, 32'h0);
  endfunction

  // Entered on the negedge where sweep write 0 is visible; leaves on the
  // negedge of the first IDLE cycle after completion.
  task automatic sweep_writes(input string tag, input int clear_at);
    for (int k = 0; k < 32; k++) begin
      chk1($sformatf("%s_acc%0d", tag, k), reg_access, 1'b1);
      chkp($sformatf("%s_pkt%0d", tag, k), reg_packet, sweep_exp(k));
      chk1($sformatf("%s_wait%0d", tag, k), host_wait_out, 1'b1);
      chk1($sformatf("%s_init%0d", tag, k), init_done, 1'b0);
      chk1($sformatf("%s_pulse%0d", tag, k), done_pulse, 1'b0);
      clear_req = (k == clear_at);
      @(negedge clk);
    end
    clear_req = 1'b0;
    chk1({tag, "_end_acc"}, reg_access, 1'b0);
    chk1({tag, "_end_pulse"}, done_pulse, 1'b1);
    chk1({tag, "_end_init"}, init_done, 1'b1);
    chk1({tag, "_end_busy"}, busy, 1'b0);
    chk1({tag, "_end_wait"}, host_wait_out, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nreset         = 1'b1;
    clear_req      = 1'b0;
    host_access_in = 1'b0;
    host_packet_in = '0;
    #1 nreset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk1("rst_acc", reg_access, 1'b0);
    chkp("rst_pkt", reg_packet, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_wait", host_wait_out, 1'b0);
    chk1("rst_init", init_done, 1'b0);
    chk1("rst_pulse", done_pulse, 1'b0);

    // 1: auto sweep after reset release
    nreset = 1'b1;
    @(negedge clk);
    chk1("t1_busy0", busy, 1'b1);
    chk1("t1_acc0", reg_access, 1'b0);
    @(negedge clk);
    chkp("t1_w0", reg_packet, mk_pkt(32'h000F0000, 32'h0, 32'h0));
    sweep_writes("t1", -1);
    @(negedge clk);
    chk1("t1_pulse_off", done_pulse, 1'b0);
    chk1("t1_init_hold", init_done, 1'b1);

    // 2: host write forwarded with one cycle of latency
    host_packet_in = mk_pkt(32'h000F0010, 32'h12345678, 32'h0);
    host_access_in = 1'b1;
    chk1("t2_acc_pre", reg_access, 1'b0);
    @(negedge clk);
    chk1("t2_acc", reg_access, 1'b1);
    chkp("t2_pkt", reg_packet, mk_pkt(32'h000F0010, 32'h12345678, 32'h0));
    chk1("t2_wait", host_wait_out, 1'b0);
    host_access_in = 1'b0;
    @(negedge clk);
    chk1("t2_acc_post", reg_access, 1'b0);

    // 3: host access held across a sweep
    clear_req = 1'b1;
    @(negedge clk);
    clear_req      = 1'b0;
    host_packet_in = mk_pkt(32'h000F0020, 32'hCAFEF00D, 32'h00001234);
    host_access_in = 1'b1;
    chk1("t3_wait", host_wait_out, 1'b1);
    chk1("t3_acc_pre", reg_access, 1'b0);
    @(negedge clk);
    sweep_writes("t3", -1);
    @(negedge clk);
    chk1("t3_host_acc", reg_access, 1'b1);
    chkp("t3_host_pkt", reg_packet, mk_pkt(32'h000F0020, 32'hCAFEF00D, 32'h00001234));
    host_access_in = 1'b0;
    @(negedge clk);
    chk1("t3_acc_post", reg_access, 1'b0);

    // 4: clear_req during a sweep is ignored
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    @(negedge clk);
    sweep_writes("t4", 10);
    @(negedge clk);
    chk1("t4_pulse_off", done_pulse, 1'b0);
    chk1("t4_busy_off", busy, 1'b0);
    chk1("t4_acc_off", reg_access, 1'b0);
    @(negedge clk);
    chk1("t4_no_restart", busy, 1'b0);

    // 5: reset in the middle of a sweep
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      chkp($sformatf("t5_pre%0d", k), reg_packet, sweep_exp(k));
      @(negedge clk);
    end
    chkp("t5_w20", reg_packet, sweep_exp(20));
    nreset = 1'b0;
    #1;
    chk1("t5_rst_acc", reg_access, 1'b0);
    chk1("t5_rst_busy", busy, 1'b0);
    chk1("t5_rst_init", init_done, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk1("t5_busy0", busy, 1'b1);
    chk1("t5_acc0", reg_access, 1'b0);
    @(negedge clk);
    sweep_writes("t5", -1);
    @(negedge clk);

    // 6: clear_req and host access in the same IDLE cycle
    chk1("t6_init_pre", init_done, 1'b1);
    host_packet_in = mk_pkt(32'h000F0030, 32'hA5A5A5A5, 32'h0000BEEF);
    host_access_in = 1'b1;
    clear_req      = 1'b1;
    @(negedge clk);
    chk1("t6_acc", reg_access, 1'b1);
    chkp("t6_pkt", reg_packet, mk_pkt(32'h000F0030, 32'hA5A5A5A5, 32'h0000BEEF));
    chk1("t6_init", init_done, 1'b0);
    chk1("t6_busy", busy, 1'b1);
    host_access_in = 1'b0;
    clear_req      = 1'b0;
    @(negedge clk);
    sweep_writes("t6", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
